// File: rtl/count_0_63_ctrl.sv
`timescale 1ns/1ps
// count_0_63_ctrl: prescaled 0..63 up/down counter driving the two-digit
// 7-segment decoder. Raw run/clear/load buttons and the direction switch are
// synchronised and edge-detected; a RUN/STOP state machine gates counting.
// Optional build macro COUNT_SATURATE_EN: the counter stops at 0/63 instead of
// wrapping, pulses wrap on that limit step and drops back to STOP.
module count_0_63_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       dir,
  input  logic       load_en,
  input  logic [5:0] load_val,
  output logic [5:0] count,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int DATA_W = 6;
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PRE_W-1:0]  pre, pre_nxt;
  logic [DATA_W-1:0] count_nxt;
  logic              tick_nxt, wrap_nxt;

  logic [SYNC_STAGES-1:0]             run_sync, clr_sync, ld_sync, dir_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] val_sync;
  logic                               run_prev, clr_prev, ld_prev;
  logic                               run_edge, clr_edge, ld_edge;
  logic                               step_due, step_go;
  logic [DATA_W:0]                    step_res;

  // Next count for one step plus a flag telling whether the step crossed the
  // 0/63 boundary; in saturating builds the value is pinned at the limit.
  function automatic logic [DATA_W:0] step_count(input logic [DATA_W-1:0] cur,
                                                 input logic up);
    logic              at_limit;
    logic [DATA_W-1:0] nxt;
    at_limit = up ? (cur == {DATA_W{1'b1}}) : (cur == '0);
    nxt      = up ? cur + DATA_W'(1) : cur - DATA_W'(1);
`ifdef COUNT_SATURATE_EN
    if (at_limit) nxt = cur;
`else
    nxt = nxt;
`endif
    return {at_limit, nxt};
  endfunction

  // Input synchronisers plus one extra flop per button for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sync <= '0;
      clr_sync <= '0;
      ld_sync  <= '0;
      dir_sync <= '0;
      val_sync <= '0;
      run_prev <= 1'b0;
      clr_prev <= 1'b0;
      ld_prev  <= 1'b0;
    end else begin
      run_sync <= {run_sync[SYNC_STAGES-2:0], btn_run};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], btn_clr};
      ld_sync  <= {ld_sync[SYNC_STAGES-2:0], load_en};
      dir_sync <= {dir_sync[SYNC_STAGES-2:0], dir};
      val_sync <= {val_sync[SYNC_STAGES-2:0], load_val};
      run_prev <= run_sync[SYNC_STAGES-1];
      clr_prev <= clr_sync[SYNC_STAGES-1];
      ld_prev  <= ld_sync[SYNC_STAGES-1];
    end
  end

  assign run_edge = run_sync[SYNC_STAGES-1] & ~run_prev;
  assign clr_edge = clr_sync[SYNC_STAGES-1] & ~clr_prev;
  assign ld_edge  = ld_sync[SYNC_STAGES-1] & ~ld_prev;

  // A step is due on the last prescaler cycle while running; clear and load
  // both reset the prescaler and swallow that step entirely.
  assign step_due = (state == RUN) && (pre == PRE_LAST);
  assign step_go  = step_due && !clr_edge && !ld_edge;
  assign step_res = step_count(count, dir_sync[SYNC_STAGES-1]);

  // Next-state and next-output logic: clear > load > step, then the run toggle.
  always_comb begin
    state_nxt = state;
    pre_nxt   = (state == RUN) ? pre + PRE_W'(1) : '0;
    count_nxt = count;
    tick_nxt  = 1'b0;
    wrap_nxt  = 1'b0;

    if (clr_edge) begin
      count_nxt = '0;
      pre_nxt   = '0;
    end else if (ld_edge) begin
      count_nxt = val_sync[SYNC_STAGES-1];
      pre_nxt   = '0;
    end else if (step_go) begin
      pre_nxt   = '0;
      tick_nxt  = 1'b1;
      count_nxt = step_res[DATA_W-1:0];
      wrap_nxt  = step_res[DATA_W];
    end

    // A run edge coinciding with a step still lets the step finish first.
    if (run_edge) begin
      state_nxt = (state == RUN) ? STOP : RUN;
      pre_nxt   = '0;
    end

`ifdef COUNT_SATURATE_EN
    if (step_go && step_res[DATA_W]) begin
      state_nxt = STOP;
      pre_nxt   = '0;
    end
`endif
  end

  // State, prescaler and all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STOP;
      pre   <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      pre   <= pre_nxt;
      count <= count_nxt;
      tick  <= tick_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_count_0_63_ctrl.sv
`timescale 1ns/1ps
// Testbench for count_0_63_ctrl with TICK_DIV=4, SYNC_STAGES=2: directed
// scenarios plus randomized button/switch activity against a reference model.
module tb_count_0_63_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SYNC     = 2;

  logic       clk = 1'b0;
  logic       rst_n, btn_run, btn_clr, dir, load_en;
  logic [5:0] load_val;
  logic [5:0] count;
  logic       running, tick, wrap;

  int checks   = 0;
  int failures = 0;

  count_0_63_ctrl #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_clr(btn_clr),
    .dir(dir), .load_en(load_en), .load_val(load_val),
    .count(count), .running(running), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs plus cycles elapsed in RUN since the
  // last step/clear/load/run change.
  typedef struct {
    int count;
    bit running;
    bit tick;
    bit wrap;
    int phase;
  } mstate_t;

  mstate_t    m;
  logic [SYNC:0] h_run, h_clr, h_ld, h_dir;
  logic [5:0]    h_val [0:SYNC];

  function automatic mstate_t model_next(mstate_t s, bit run_e, bit clr_e, bit ld_e,
                                         bit up, int ldv);
    mstate_t n;
    int      target;
    bit      limit;
    n      = s;
    n.tick = 1'b0;
    n.wrap = 1'b0;
    limit  = 1'b0;
    if (clr_e) begin
      n.count = 0;
      n.phase = 0;
    end else if (ld_e) begin
      n.count = ldv;
      n.phase = 0;
    end else if (s.running && s.phase == TICK_DIV - 1) begin
      n.tick = 1'b1;
      n.phase = 0;
      target = s.count + (up ? 1 : -1);
      limit  = (target < 0) || (target > 63);
`ifdef COUNT_SATURATE_EN
      n.count = limit ? s.count : target;
`else
      n.count = (target + 64) % 64;
`endif
      n.wrap = limit;
    end else if (s.running) begin
      n.phase = s.phase + 1;
    end
    if (run_e) begin
      n.running = !s.running;
      n.phase   = 0;
    end
`ifdef COUNT_SATURATE_EN
    if (limit) begin
      n.running = 1'b0;
      n.phase   = 0;
    end
`endif
    return n;
  endfunction

  // Raw inputs become visible SYNC samples later; a rise is a 0 then 1 pair.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m     <= '{count: 0, running: 1'b0, tick: 1'b0, wrap: 1'b0, phase: 0};
      h_run <= '0;
      h_clr <= '0;
      h_ld  <= '0;
      h_dir <= '0;
      for (int i = 0; i <= SYNC; i++) h_val[i] <= '0;
    end else begin
      m <= model_next(m, h_run[SYNC-1] && !h_run[SYNC], h_clr[SYNC-1] && !h_clr[SYNC],
                      h_ld[SYNC-1] && !h_ld[SYNC], h_dir[SYNC-1], int'(h_val[SYNC-1]));
      h_run <= {h_run[SYNC-1:0], btn_run};
      h_clr <= {h_clr[SYNC-1:0], btn_clr};
      h_ld  <= {h_ld[SYNC-1:0], load_en};
      h_dir <= {h_dir[SYNC-1:0], dir};
      h_val[0] <= load_val;
      for (int i = 1; i <= SYNC; i++) h_val[i] <= h_val[i-1];
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; btn_run = 1'b0; btn_clr = 1'b0; load_en = 1'b0;
    dir = 1'b0; load_val = 6'd0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
    end
  endtask

  task automatic test_run_up();
    int   entries;
    logic run_q;
    dir = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    entries = 0;
    run_q   = running;
    btn_run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (running && !run_q) entries++;
      run_q = running;
      checks++;
      if (running !== (i >= SYNC + 1)) begin
        failures++; $display("FAIL run_up_running i=%0d got=%b exp=%b", i, running, (i >= SYNC + 1));
      end
      checks++;
      if (tick !== (i >= SYNC + 1 + TICK_DIV && (i - SYNC - 1) % TICK_DIV == 0)) begin
        failures++; $display("FAIL run_up_tick i=%0d got=%b", i, tick);
      end
      checks++;
      if (count !== 6'((i >= SYNC + 1) ? (i - SYNC - 1) / TICK_DIV : 0)) begin
        failures++; $display("FAIL run_up_count i=%0d got=%0d exp=%0d", i, count, (i >= SYNC + 1) ? (i - SYNC - 1) / TICK_DIV : 0);
      end
      checks++;
      if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
        failures++;
        $display("FAIL run_up_model i=%0d got=%h exp=%h", i, {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
      end
      if (i == 10) btn_run = 1'b0;
    end
    checks++; if (entries != 1) begin failures++; $display("FAIL run_up_entries got=%0d exp=1", entries); end
  endtask

  task automatic test_wrap_up();
    int hold;
    load_val = 6'd62;
    repeat (SYNC + 1) @(negedge clk);
    hold    = $urandom_range(1, 6);
    load_en = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      checks++;
      if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
        failures++;
        $display("FAIL wrap_up_model i=%0d got=%h exp=%h", i, {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
      end
      checks++;
      if (wrap !== (i == 11)) begin failures++; $display("FAIL wrap_up_wrap i=%0d got=%b exp=%b", i, wrap, (i == 11)); end
      if (i == 3 || i == 7 || i == 11) begin
        checks++;
        if ({count, tick} !== ((i == 3) ? {6'd62, 1'b0} : (i == 7) ? {6'd63, 1'b1} : {6'd0, 1'b1})) begin
          failures++; $display("FAIL wrap_up_seq i=%0d got cnt=%0d tick=%b", i, count, tick);
        end
      end
      if (i == hold) load_en = 1'b0;
    end
    load_en = 1'b0;
  endtask

  task automatic test_wrap_down();
    logic [5:0] exp_cnt;
    logic       exp_run;
`ifdef COUNT_SATURATE_EN
    exp_cnt = 6'd0;
    exp_run = 1'b0;
`else
    exp_cnt = 6'd63;
    exp_run = 1'b1;
`endif
    dir = 1'b0; load_val = 6'd1; load_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
        failures++;
        $display("FAIL wrap_down_model i=%0d got=%h exp=%h", i, {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
      end
      checks++;
      if (wrap !== (i == 11)) begin failures++; $display("FAIL wrap_down_wrap i=%0d got=%b exp=%b", i, wrap, (i == 11)); end
      if (i == 3) begin
        checks++; if (count !== 6'd1) begin failures++; $display("FAIL wrap_down_load got=%0d exp=1", count); end
      end
      if (i == 7) begin
        checks++; if ({count, tick} !== {6'd0, 1'b1}) begin failures++; $display("FAIL wrap_down_to0 got cnt=%0d tick=%b exp cnt=0 tick=1", count, tick); end
      end
      if (i == 11) begin
        checks++;
        if ({count, running} !== {exp_cnt, exp_run}) begin
          failures++; $display("FAIL wrap_down_limit got cnt=%0d run=%b exp cnt=%0d run=%b", count, running, exp_cnt, exp_run);
        end
      end
      if (i == 2) load_en = 1'b0;
    end
  endtask

  task automatic ensure_running();
    if (!running) begin
      btn_run = 1'b1;
      repeat (4) @(negedge clk);
      btn_run = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_clr_load();
    logic run_before;
    ensure_running();
    dir = 1'b1; load_val = 6'd40;
    repeat (SYNC + 1) @(negedge clk);
    run_before = running;
    btn_clr = 1'b1; load_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
        failures++;
        $display("FAIL clr_load_model i=%0d got=%h exp=%h", i, {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
      end
      if (i == SYNC + 1) begin
        checks++;
        if ({count, tick, wrap, running} !== {6'd0, 1'b0, 1'b0, run_before}) begin
          failures++;
          $display("FAIL clr_load_prio got cnt=%0d tick=%b wrap=%b run=%b exp cnt=0 tick=0 wrap=0 run=%b", count, tick, wrap, running, run_before);
        end
      end
      if (i == 4) begin btn_clr = 1'b0; load_en = 1'b0; end
    end
  endtask

  task automatic test_stop_hold();
    bit found;
    int n;
    ensure_running();
    load_val = 6'd4; load_en = 1'b1;
    repeat (2) @(negedge clk);
    load_en = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1 && count === 6'd5) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL stop_reach5 got=%0d exp=5", count); end
    btn_run = 1'b1;
    for (int i = 1; i <= 53; i++) begin
      @(negedge clk);
      checks++;
      if ({count, tick} !== {6'd5, 1'b0}) begin failures++; $display("FAIL stop_hold i=%0d got cnt=%0d tick=%b exp cnt=5 tick=0", i, count, tick); end
      if (i >= SYNC + 1) begin
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_running i=%0d got=%b exp=0", i, running); end
      end
      checks++;
      if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
        failures++;
        $display("FAIL stop_model i=%0d got=%h exp=%h", i, {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
      end
      if (i == 4) btn_run = 1'b0;
    end
    btn_run = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      checks++;
      if ({running, tick, count} !== {(j >= SYNC + 1), (j == SYNC + 1 + TICK_DIV), ((j >= SYNC + 1 + TICK_DIV) ? 6'd6 : 6'd5)}) begin
        failures++; $display("FAIL restart_first_tick j=%0d got run=%b tick=%b cnt=%0d", j, running, tick, count);
      end
      checks++;
      if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
        failures++;
        $display("FAIL restart_model j=%0d got=%h exp=%h", j, {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
      end
      if (j == 2) btn_run = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    bit   found;
    int   n, entries;
    logic run_q;
    found = 1'b0; n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      n++;
      if (count === 6'd17) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL async_reach17 got=%0d exp=17", count); end
    btn_run = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL async_rst_count got=%0d exp=0", count); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL async_rst_running got=%b exp=0", running); end
    checks++; if ({tick, wrap} !== 2'b00) begin failures++; $display("FAIL async_rst_pulses got=%b exp=00", {tick, wrap}); end
    #1 rst_n = 1'b1;
    entries = 0;
    run_q   = running;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (running && !run_q) entries++;
      run_q = running;
      checks++;
      if (running !== (i >= SYNC + 1)) begin failures++; $display("FAIL async_run_entry i=%0d got=%b exp=%b", i, running, (i >= SYNC + 1)); end
      checks++;
      if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
        failures++;
        $display("FAIL async_model i=%0d got=%h exp=%h", i, {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
      end
      if (i == SYNC + 1 + TICK_DIV) begin
        checks++; if ({count, tick} !== {6'd1, 1'b1}) begin failures++; $display("FAIL async_first_step got cnt=%0d tick=%b exp cnt=1 tick=1", count, tick); end
      end
      if (i == 12) btn_run = 1'b0;
    end
    checks++; if (entries != 1) begin failures++; $display("FAIL async_entries got=%0d exp=1", entries); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if ({count, running, tick, wrap} !== {6'(m.count), m.running, m.tick, m.wrap}) begin
        failures++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c, {count, running, tick, wrap}, {6'(m.count), m.running, m.tick, m.wrap});
      end
      if ($urandom_range(0, 24) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 59) == 0) btn_clr = ~btn_clr;
      if ($urandom_range(0, 39) == 0) load_en = ~load_en;
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 7) == 0) load_val = 6'($urandom_range(0, 63));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_run_up();
    test_wrap_up();
    test_wrap_down();
    test_clr_load();
    test_stop_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
